// File: rtl/ibex_pkg.sv
// Shared types for the load/store path: access size encoding, the bus
// controller FSM states, and the helper that decides when an access spans two words.
package ibex_pkg;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_type_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT_MIS,
    WAIT_RVALID_MIS,
    WAIT_GNT,
    WAIT_RVALID,
    MIS_ERR
  } ls_fsm_e;

  // An access needs two bus words when its bytes run past lane 3.
  function automatic logic lsu_is_split(lsu_type_e lsu_type, logic [1:0] offset);
    return ((lsu_type == LSU_WORD) && (offset != 2'b00)) ||
           ((lsu_type == LSU_HALF) && (offset == 2'b11));
  endfunction

endpackage

// File: rtl/ibex_lsu_align.sv
// Combinational formatting for the data bus: byte enables per part, store data
// rotation into byte lanes, and load data extraction plus zero/sign extension.
module ibex_lsu_align
  import ibex_pkg::*;
(
  input  lsu_type_e   lsu_type,
  input  logic [1:0]  offset,
  input  logic        part,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [31:0] rdata_q,
  output logic [3:0]  be,
  output logic [31:0] wdata_rot,
  output logic [31:0] rdata_ext
);

  logic [7:0]  be_base;
  logic [7:0]  be_span;
  logic [63:0] rdata_cat;
  logic [31:0] rdata_sh;

  // Shifting an 8-lane mask leaves the second word's lanes in the upper nibble.
  always_comb begin
    be_base = 8'b0000_0001;
    case (lsu_type)
      LSU_WORD: be_base = 8'b0000_1111;
      LSU_HALF: be_base = 8'b0000_0011;
      default:  be_base = 8'b0000_0001;
    endcase
    be_span = be_base << offset;
    be      = part ? be_span[7:4] : be_span[3:0];
  end

  always_comb begin
    wdata_rot = wdata;
    case (offset)
      2'd1:    wdata_rot = {wdata[23:0], wdata[31:24]};
      2'd2:    wdata_rot = {wdata[15:0], wdata[31:16]};
      2'd3:    wdata_rot = {wdata[7:0],  wdata[31:8]};
      default: wdata_rot = wdata;
    endcase
  end

  // The second part's word sits above the first part's captured word.
  assign rdata_cat = part ? {rdata, rdata_q} : {32'b0, rdata};
  assign rdata_sh  = rdata_cat[{offset, 3'b000} +: 32];

  always_comb begin
    rdata_ext = rdata_sh;
    case (lsu_type)
      LSU_HALF: rdata_ext = {{16{sign_ext & rdata_sh[15]}}, rdata_sh[15:0]};
      LSU_BYTE: rdata_ext = {{24{sign_ext & rdata_sh[7]}},  rdata_sh[7:0]};
      default:  rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/ibex_data_bus_ctrl.sv
// Load/store bus controller: issues one LSU access at a time on the req/gnt/rvalid
// data bus, splitting word-crossing accesses into two transactions.
module ibex_data_bus_ctrl
  import ibex_pkg::*;
#(
  parameter logic SplitMisaligned = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  lsu_type_e   lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_req_done_o,
  output logic        lsu_busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rdata_valid_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic [31:0] addr_last_o,
  output ls_fsm_e     fsm_state_o
);

  // Bus handshake: a transaction is issued in the cycle where data_req_o and
  // data_gnt_i are both high; its single response is the next data_rvalid_i pulse.
  // lsu_req_i stays high with stable fields until lsu_req_done_o is seen.

  ls_fsm_e     state_q, state_d;
  logic        we_q, sext_q, err_q;
  lsu_type_e   type_q;
  logic [31:0] addr_q, wdata_q, rdata_q, addr_last_q;

  logic        in_idle, split, part;
  lsu_type_e   cur_type;
  logic [31:0] cur_addr, cur_wdata, word_addr, second_addr;
  logic [3:0]  be;
  logic [31:0] wdata_rot, rdata_ext;
  logic        req, done, resp_valid, resp_err, accept, capture, second_err;

  // In IDLE the bus fields come straight from the request, afterwards from the latches.
  assign in_idle     = (state_q == IDLE);
  assign cur_type    = in_idle ? lsu_type_i  : type_q;
  assign cur_addr    = in_idle ? lsu_addr_i  : addr_q;
  assign cur_wdata   = in_idle ? lsu_wdata_i : wdata_q;
  assign split       = lsu_is_split(cur_type, cur_addr[1:0]);
  assign part        = split & ((state_q == WAIT_GNT) | (state_q == WAIT_RVALID));
  assign second_addr = {addr_q[31:2], 2'b00} + 32'd4;
  assign word_addr   = {cur_addr[31:2], 2'b00} + (part ? 32'd4 : 32'd0);

  ibex_lsu_align u_align (
    .lsu_type  (cur_type),
    .offset    (cur_addr[1:0]),
    .part      (part),
    .sign_ext  (in_idle ? lsu_sign_ext_i : sext_q),
    .wdata     (cur_wdata),
    .rdata     (data_rdata_i),
    .rdata_q   (rdata_q),
    .be        (be),
    .wdata_rot (wdata_rot),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    done       = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    second_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          accept = 1'b1;
          if (split && !SplitMisaligned) begin
            state_d = MIS_ERR;
            done    = 1'b1;
          end else begin
            req = 1'b1;
            if (data_gnt_i) begin
              state_d = split ? WAIT_RVALID_MIS : WAIT_RVALID;
              done    = ~split;
            end else begin
              state_d = split ? WAIT_GNT_MIS : WAIT_GNT;
            end
          end
        end
      end
      WAIT_GNT_MIS: begin
        req = 1'b1;
        if (data_gnt_i) state_d = WAIT_RVALID_MIS;
      end
      WAIT_RVALID_MIS: begin
        // The second part goes out even if the first one errored.
        if (data_rvalid_i) begin
          capture = 1'b1;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (data_gnt_i) begin
          state_d = WAIT_RVALID;
          done    = 1'b1;
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          resp_valid = 1'b1;
          resp_err   = err_q | data_err_i;
          second_err = split & data_err_i & ~err_q;
          state_d    = IDLE;
        end
      end
      MIS_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      type_q      <= LSU_WORD;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      addr_last_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q        <= lsu_we_i;
        type_q      <= lsu_type_i;
        sext_q      <= lsu_sign_ext_i;
        addr_q      <= lsu_addr_i;
        wdata_q     <= lsu_wdata_i;
        err_q       <= 1'b0;
        addr_last_q <= lsu_addr_i;
      end
      if (capture) begin
        rdata_q <= data_rdata_i;
        err_q   <= data_err_i;
      end
      if (second_err) addr_last_q <= second_addr;
    end
  end

  // Every output is forced low while reset is asserted.
  assign data_req_o        = ~rst_i & req;
  assign data_addr_o       = rst_i ? '0 : word_addr;
  assign data_we_o         = ~rst_i & (in_idle ? lsu_we_i : we_q);
  assign data_be_o         = rst_i ? '0 : be;
  assign data_wdata_o      = rst_i ? '0 : wdata_rot;
  assign lsu_req_done_o    = ~rst_i & done;
  assign lsu_busy_o        = ~rst_i & ~in_idle;
  assign lsu_resp_valid_o  = ~rst_i & resp_valid;
  assign lsu_resp_err_o    = ~rst_i & resp_err;
  assign lsu_rdata_o       = rst_i ? '0 : rdata_ext;
  assign lsu_rdata_valid_o = lsu_resp_valid_o & ~we_q & ~lsu_resp_err_o;
  assign load_err_o        = lsu_resp_err_o & ~we_q;
  assign store_err_o       = lsu_resp_err_o & we_q;
  assign addr_last_o       = rst_i ? '0 : (second_err ? second_addr : addr_last_q);
  assign fsm_state_o       = rst_i ? IDLE : state_q;

endmodule
